fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Consumer end of the program-counter interface. Takes the current PC from the PC register, issues instruction-memory reads, and buffers the returned instructions in order. Presents them to decode with a valid/ready handshake.
- Drives the PC register's write-enable back upstream: the PC advances only when a fetch is accepted or a redirect occurs.
- Flushes wrong-path work when the branch-select redirect fires.

Parameters:
- DEPTH, 4, queue entries (power of 2, ≥2); also the bound on requests in flight plus instructions buffered.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- pc_in  in  XLEN  current PC from the PC register
- pcsrc_in  in  1  redirect/branch-taken; same signal that selects the branch target in the PC register
- pc_write_en  out  1  PC-register write enable (1 = advance/load, 0 = hold)
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch address (= pc_in)
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  response valid; responses return in request order, 1 per cycle max
- imem_rsp_data  in  XLEN  instruction word
- id_valid  out  1  head instruction available to decode
- id_ready  in  1  decode accepts the head instruction
- id_instr  out  XLEN  head instruction
- id_pc  out  XLEN  PC of the head instruction
- id_pc_plus_4  out  XLEN  id_pc + 4, modulo 2^XLEN

Behaviour:
- Storage: DEPTH slots, each holding {pc, instr, filled}. Three pointers:
  - alloc_ptr: slot reserved at issue, pc captured there
  - fill_ptr: next slot written by a response
  - head_ptr: oldest slot
- Pointers wrap modulo DEPTH. An occupancy counter (0..DEPTH) counts reserved slots.
- drop_cnt (0..DEPTH) counts outstanding responses that belong to flushed requests.
- Issue:
  - imem_req_valid = (occupancy < DEPTH) && !pcsrc_in; independent of imem_req_ready.
  - fire = imem_req_valid && imem_req_ready. On fire, reserve slot alloc_ptr with pc = pc_in and filled = 0.
- PC control: pc_write_en = fire || pcsrc_in. The PC holds whenever no request is accepted and no redirect occurs.
- Response:
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: write instr into slot fill_ptr, set filled, advance fill_ptr.
  - A response with nothing outstanding is illegal; the bench flags it.
- Decode output:
  - id_valid = filled[head_ptr].
  - id_instr, id_pc and id_pc_plus_4 are driven from the head slot.
  - Pop on id_valid && id_ready: clear filled, advance head_ptr, decrement occupancy.
- Minimum latency: request fires in cycle N, response arrives in N+1, id_valid is high in N+2. There is no bypass path.
- Full: occupancy == DEPTH deasserts imem_req_valid, so pc_write_en = 0 (stall).
  - Pop and fire in the same cycle leave occupancy unchanged.
  - A pop while full allows a fire in the next cycle, not the same cycle.
- Redirect (pcsrc_in = 1), highest priority:
  - No fire and no pop this cycle.
  - All slots are cleared, all pointers go to 0, occupancy goes to 0.
  - drop_cnt is set to (drop_cnt + non-dropped in-flight count) minus 1 if a response arrives this cycle. In-flight count = occupancy minus filled slots minus in-flight responses already accounted.
  - The next cycle fetches from the redirected PC.
- Simultaneous redirect and response: the response is treated as wrong-path. It is either consumed from drop_cnt or discarded, never written.
- Reset (asynchronous, active-low):
  - Pointers, occupancy, drop_cnt and filled bits are 0.
  - Outputs: imem_req_valid = 0, pc_write_en = 0, id_valid = 0, id_instr = 0, id_pc = 0, id_pc_plus_4 = 4.
  - Reset asserted mid-operation abandons in-flight requests; the memory model is reset alongside.

Decomposition:
- Shared package: XLEN, instruction NOP constant (32'h00000013), fetch-slot struct {pc, instr, filled}.
- One natural sub-module: fetch_slot_ram (DEPTH × slot storage with separate alloc/fill write ports and head read).
- Counters and control stay in fetch_queue.

Test Plan:
- Streaming: reset, pc_in follows the PC register from 0, memory always ready with 1-cycle latency, id_ready = 1.
  - Expected: id_pc = 0x0, 0x4, 0x8, … one per cycle from cycle 2; id_pc_plus_4 = id_pc + 4.
- Backpressure: id_ready = 0 with DEPTH = 4.
  - Expected: exactly 4 fires, then imem_req_valid = 0 and pc_write_en = 0. After id_ready = 1, one fire per pop and order is preserved (0x0, 0x4, 0x8, 0xC, 0x10).
- Flush with in-flight work: 3-cycle memory latency, 2 requests outstanding and 1 filled slot, then pcsrc_in pulse with PC_Branch = 0x100.
  - Expected: id_valid = 0 next cycle, both late responses discarded, first delivered id_pc = 0x100.
- Same-cycle redirect and response: response arrives in the cycle pcsrc_in = 1.
  - Expected: that instruction never appears on the id_ bus and drop_cnt returns to 0.
- Memory stall: imem_req_ready = 0 for 5 cycles.
  - Expected: pc_write_en = 0 throughout and pc_in is unchanged; fetch resumes at the same PC.
- Asynchronous reset: reset_n deasserted mid-stream between clock edges.
  - Expected: id_valid and imem_req_valid drop immediately; after release, fetch restarts with id_pc = 0x0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_ram.sv
// Slot storage for the fetch queue: alloc writes pc, fill writes instr, head is read.
module fetch_slot_ram
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              alloc_we_i,
  input  logic [AW-1:0]     alloc_idx_i,
  input  logic [XLEN-1:0]   alloc_pc_i,
  input  logic              fill_we_i,
  input  logic [AW-1:0]     fill_idx_i,
  input  logic [XLEN-1:0]   fill_instr_i,
  input  logic              pop_i,
  input  logic [AW-1:0]     head_idx_i,
  output fetch_slot_t       head_o
);

  fetch_slot_t slots_q [DEPTH];
  fetch_slot_t slots_d [DEPTH];

  // Alloc, fill and pop never target the same slot in one cycle.
  always_comb begin
    slots_d = slots_q;
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_d[i] = '0;
      end
    end else begin
      if (alloc_we_i) begin
        slots_d[alloc_idx_i] = '{pc: alloc_pc_i, instr: NOP, filled: 1'b0};
      end
      if (fill_we_i) begin
        slots_d[fill_idx_i].instr  = fill_instr_i;
        slots_d[fill_idx_i].filled = 1'b1;
      end
      if (pop_i) begin
        slots_d[head_idx_i].filled = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      slots_q <= slots_d;
    end
  end

  assign head_o = slots_q[head_idx_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: issues imem reads at the PC, buffers responses in order, hands them to decode,
// and drops wrong-path responses after a redirect.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = fetch_queue_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pcsrc_in,
  output logic            pc_write_en,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus_4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [AW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic [AW-1:0] head_ptr_q, head_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] drop_q, drop_d;
  // Correct-path requests still waiting for their response.
  logic [CW-1:0] pend_q, pend_d;

  logic fire, pop, fill_we, rsp_drop;
  fetch_queue_pkg::fetch_slot_t head;

  always_comb begin
    imem_req_valid = reset_n && (occ_q < DepthC) && !pcsrc_in;
    fire           = imem_req_valid && imem_req_ready;
    pc_write_en    = fire || (reset_n && pcsrc_in);
    id_valid       = head.filled;
    pop            = id_valid && id_ready && !pcsrc_in;
    rsp_drop       = imem_rsp_valid && (drop_q != '0);
    fill_we        = imem_rsp_valid && !rsp_drop && (pend_q != '0) && !pcsrc_in;
  end

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    occ_d       = occ_q;
    drop_d      = drop_q;
    pend_d      = pend_q;
    if (pcsrc_in) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      occ_d       = '0;
      pend_d      = '0;
      // A response arriving now is one of the flushed requests.
      drop_d      = drop_q + pend_q - CW'(imem_rsp_valid);
    end else begin
      if (fire)    alloc_ptr_d = alloc_ptr_q + AW'(1);
      if (fill_we) fill_ptr_d  = fill_ptr_q + AW'(1);
      if (pop)     head_ptr_d  = head_ptr_q + AW'(1);
      occ_d  = occ_q + CW'(fire) - CW'(pop);
      pend_d = pend_q + CW'(fire) - CW'(fill_we);
      if (rsp_drop) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      drop_q      <= '0;
      pend_q      <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      occ_q       <= occ_d;
      drop_q      <= drop_d;
      pend_q      <= pend_d;
    end
  end

  fetch_slot_ram #(
    .DEPTH(DEPTH)
  ) u_slot_ram (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .clear_i      (pcsrc_in),
    .alloc_we_i   (fire),
    .alloc_idx_i  (alloc_ptr_q),
    .alloc_pc_i   (pc_in),
    .fill_we_i    (fill_we),
    .fill_idx_i   (fill_ptr_q),
    .fill_instr_i (imem_rsp_data),
    .pop_i        (pop),
    .head_idx_i   (head_ptr_q),
    .head_o       (head)
  );

  assign imem_req_addr = pc_in;
  assign id_instr      = head.instr;
  assign id_pc         = head.pc;
  assign id_pc_plus_4  = head.pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue with a PC-register model and a fixed-latency memory model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [XLEN-1:0] pc_in = '0;
  logic            pcsrc_in = 1'b0;
  logic            pc_write_en;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready = 1'b0;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic            id_valid;
  logic            id_ready = 1'b0;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus_4;

  fetch_queue #(
    .DEPTH(DEPTH),
    .XLEN (XLEN)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_in          (pc_in),
    .pcsrc_in       (pcsrc_in),
    .pc_write_en    (pc_write_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus_4   (id_pc_plus_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          fires = 0;
  int          pops = 0;
  int          first_pop = -1;
  logic [31:0] pc_reg = '0;
  logic [31:0] branch_pc = '0;
  logic [31:0] seq_pc = '0;
  logic [31:0] held_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) ^ 32'hC0DE_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_rsp();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // One clock: sample at negedge, update models 1 time unit after posedge.
  task automatic cycle();
    logic        f, pwe, psrc, rv, pp;
    logic [31:0] fpc, e;
    @(negedge clk);
    f  = imem_req_valid && imem_req_ready;
    pp = id_valid && id_ready && !pcsrc_in;
    check_eq("pc_we", 32'(pc_write_en), 32'(f || pcsrc_in));
    if (imem_req_valid) check_eq("req_addr", imem_req_addr, pc_in);
    if (pp) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("id_pc", id_pc, e);
        check_eq("id_instr", id_instr, mem_word(e));
        check_eq("id_pc4", id_pc_plus_4, e + 32'd4);
      end
      check_eq("seq_pc", id_pc, seq_pc);
      seq_pc = seq_pc + 32'd4;
    end
    pwe  = pc_write_en;
    psrc = pcsrc_in;
    rv   = imem_rsp_valid;
    fpc  = pc_in;
    @(posedge clk);
    #1;
    if (psrc) sb.delete();
    if (rv && mq.size() > 0) void'(mq.pop_front());
    if (f) begin
      sb.push_back(fpc);
      mq.push_back('{addr: fpc, due: cyc + lat});
      fires++;
    end
    cyc++;
    if (pwe) pc_reg = psrc ? branch_pc : pc_reg + 32'd4;
    pc_in = pc_reg;
    drive_rsp();
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    pcsrc_in       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    check_eq("rst_id_vld", 32'(id_valid), 32'd0);
    check_eq("rst_req_vld", 32'(imem_req_valid), 32'd0);
    check_eq("rst_pc_we", 32'(pc_write_en), 32'd0);
    check_eq("rst_instr", id_instr, 32'd0);
    check_eq("rst_pc", id_pc, 32'd0);
    check_eq("rst_pc4", id_pc_plus_4, 32'd4);
    mq.delete();
    sb.delete();
    pc_reg    = '0;
    pc_in     = '0;
    cyc       = 0;
    fires     = 0;
    pops      = 0;
    first_pop = -1;
    seq_pc    = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Streaming
    do_reset();
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    repeat (12) cycle();
    check_eq("stream_first", 32'(first_pop), 32'd2);
    check_eq("stream_pops", 32'(pops), 32'd10);

    // Backpressure
    do_reset();
    id_ready = 1'b0;
    repeat (8) cycle();
    check_eq("bp_fires", 32'(fires), 32'(DEPTH));
    check_eq("bp_req_vld", 32'(imem_req_valid), 32'd0);
    check_eq("bp_pc_we", 32'(pc_write_en), 32'd0);
    check_eq("bp_id_vld", 32'(id_valid), 32'd1);
    id_ready = 1'b1;
    #1 check_eq("bp_full_nofire", 32'(imem_req_valid), 32'd0);
    repeat (10) cycle();
    check_eq("bp_pops", 32'(pops >= 5), 32'd1);

    // Flush with two in flight and one filled
    do_reset();
    lat = 3; id_ready = 1'b0;
    imem_req_ready = 1'b1; cycle();
    imem_req_ready = 1'b0; cycle();
    imem_req_ready = 1'b1; cycle(); cycle();
    imem_req_ready = 1'b0;
    #1;
    check_eq("fl_pre_vld", 32'(id_valid), 32'd1);
    check_eq("fl_pre_pc", id_pc, 32'd0);
    branch_pc = 32'h100; pcsrc_in = 1'b1; seq_pc = 32'h100;
    cycle();
    pcsrc_in = 1'b0;
    check_eq("fl_id_vld", 32'(id_valid), 32'd0);
    check_eq("fl_drop2", 32'(dut.drop_q), 32'd2);
    imem_req_ready = 1'b1; id_ready = 1'b1;
    repeat (12) cycle();
    check_eq("fl_pops", 32'(pops > 0), 32'd1);
    check_eq("fl_drop0", 32'(dut.drop_q), 32'd0);

    // Redirect in the same cycle as a response
    do_reset();
    lat = 2; id_ready = 1'b1; imem_req_ready = 1'b1;
    cycle(); cycle();
    branch_pc = 32'h200; pcsrc_in = 1'b1; seq_pc = 32'h200;
    #1 check_eq("sc_no_req", 32'(imem_req_valid), 32'd0);
    cycle();
    pcsrc_in = 1'b0;
    check_eq("sc_drop1", 32'(dut.drop_q), 32'd1);
    cycle();
    check_eq("sc_drop0", 32'(dut.drop_q), 32'd0);
    repeat (8) cycle();
    check_eq("sc_pops", 32'(pops > 0), 32'd1);

    // Memory stall
    do_reset();
    lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (6) cycle();
    imem_req_ready = 1'b0;
    held_pc = pc_in;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("ms_pc_we", 32'(pc_write_en), 32'd0);
      check_eq("ms_pc_hold", pc_in, held_pc);
      cycle();
    end
    imem_req_ready = 1'b1;
    #1 check_eq("ms_resume_addr", imem_req_addr, held_pc);
    repeat (8) cycle();
    check_eq("ms_pops", 32'(pops), 32'd12);

    // Asynchronous reset mid-stream
    #2 check_eq("ar_pre_vld", 32'(id_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("ar_id_vld", 32'(id_valid), 32'd0);
    check_eq("ar_req_vld", 32'(imem_req_valid), 32'd0);
    do_reset();
    repeat (6) cycle();
    check_eq("ar_first", 32'(first_pop), 32'd2);
    check_eq("ar_pops", 32'(pops), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
